mic_sample_deser: RTL
=====================

// Module: mic_sample_deser
// PURPOSE
//  Downstream stage of the PmodMIC chip-select FSM. Samples the ADC serial line on clk_sclk
//  while the FSM holds ncs low, builds one 16-bit frame (4 leading zeros + 12-bit sample MSB-first),
//  and validates it. Queues good samples in a small FIFO for the audio datapath (valid/ready).
//  Flags framing errors and FIFO overruns. Runs entirely in the clk_sclk domain.
// PARAMETERS
//  DATA_W      12  sample width delivered to consumer
//  LEAD_ZEROS  4   leading zero bits per frame; frame length FRAME_LEN = DATA_W+LEAD_ZEROS = 16
//  FIFO_DEPTH  4   sample queue depth, power of two, >= 2
// PORTS
//  clk_sclk      in   1       serial clock, same net that clocks the chip-select FSM
//  rst           in   1       reset, asynchronous, active-high
//  ncs           in   1       chip select from FSM (cntr_ncs), low = frame in progress
//  sdata         in   1       ADC serial data, changes on falling edge
//  sample_data   out  DATA_W  head-of-FIFO sample
//  sample_valid  out  1       FIFO not empty
//  sample_ready  in   1       consumer accepts head when valid&&ready at posedge
//  frame_err     out  1       one-cycle pulse: frame discarded (length or zero-header error)
//  overrun       out  1       one-cycle pulse: good frame dropped because FIFO full
//  ovr_count     out  8       saturating count of overrun events
// BEHAVIOUR
//  - All logic on posedge clk_sclk (mid-bit of data launched on negedge); async reset.
//  - Reset: shift reg 0, bit_cnt 0, FIFO empty, sample_valid 0, sample_data 0, frame_err 0,
//    overrun 0, ovr_count 0. Reset mid-frame abandons the partial frame; no flag raised.
//  - ncs low: if bit_cnt < FRAME_LEN shift sdata in LSB-side, bit_cnt++; else set long_flag, ignore bit.
//  - ncs high with bit_cnt != 0 (frame end, detected on first posedge after ncs rises):
//      bit_cnt==FRAME_LEN, !long_flag, header bits [15:12]==0 -> push shreg[11:0];
//      otherwise (short, long, or nonzero header) -> discard, frame_err=1 for one cycle.
//    Then bit_cnt<=0, long_flag<=0. ncs high with bit_cnt==0: idle, nothing happens.
//  - Push latency: sample_valid rises the posedge after frame-end detection (2 edges after ncs rises).
//  - FIFO: pop on sample_valid&&sample_ready. Push while full -> drop, overrun=1, ovr_count++
//    (saturates at 255). Push and pop same cycle while full -> both proceed, no overrun.
//    Push and pop same cycle while empty -> push only (no fall-through), valid next cycle.
//  - sample_data stable while sample_valid && !sample_ready; pointers wrap modulo FIFO_DEPTH.
//  - Back-to-back frames: ncs high for a single posedge is sufficient between frames.
// CONFIGURATION
//  MIC_SIGNED_OUT_EN defined: pushed sample = {~s[11], s[10:0]} (offset binary -> two's complement,
//    mid-scale 0x800 -> 0x000). Undefined: raw offset-binary ADC code pushed unchanged.
// STRUCTURE
//  mic_pkg: FRAME_LEN, LEAD_ZEROS, DATA_W defaults, MIC_MIDSCALE=12'h800, bit-count width localparam.
//  Sub-module mic_sample_fifo (DATA_W x FIFO_DEPTH, registered read, full/empty via extra ptr bit).
//  Top holds shift reg, bit counter, frame checker, flag/counter logic.
// TESTING
//  1 ncs low 16 edges, bits 0000_1010_0101_1100, ready=1 -> sample_data=12'hA5C, valid one cycle, no flags.
//  2 Frame of 11 bits then ncs high -> frame_err one pulse, FIFO stays empty.
//  3 Header 0001 + data 12'h123 -> frame_err pulse, no push; ncs held 18 edges -> frame_err pulse.
//  4 ready=0, send 5 good frames (depth 4) -> 4 queued, 5th overrun pulse, ovr_count=1; drain yields
//    frames 1-4 in order.
//  5 FIFO full, pop and frame-end same cycle -> no overrun, count stays 4, new sample last out.
//  6 rst asserted mid-frame (bit 8) then released, full good frame 12'h800 -> exactly one sample:
//    12'h800 (MIC_SIGNED_OUT_EN undefined) / 12'h000 (defined); no frame_err.

Source files
------------

// File: rtl/mic_pkg.sv
// Shared constants and types for the PmodMIC sample deserializer.
// Defaults here describe the PmodMIC frame: 4 leading zeros followed by a 12-bit sample.
package mic_pkg;

  localparam int DATA_W_DEF     = 12;
  localparam int LEAD_ZEROS_DEF = 4;
  localparam int FRAME_LEN      = DATA_W_DEF + LEAD_ZEROS_DEF;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam logic [DATA_W_DEF-1:0] MIC_MIDSCALE = 12'h800;

  // Bit counter must hold FRAME_LEN itself, not just FRAME_LEN-1.
  localparam int BIT_CNT_W = $clog2(FRAME_LEN + 1);

  // Outcome of the frame checker on the cycle ncs is first seen high.
  typedef enum logic [1:0] {
    FR_NONE = 2'd0,
    FR_GOOD = 2'd1,
    FR_BAD  = 2'd2
  } frame_evt_e;

  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/mic_sample_fifo.sv
// Small sample queue: DATA_W x DEPTH, registered head output, full/empty from an extra pointer bit.
// A write while full is refused and reported on drop unless a pop frees a slot in the same cycle.
module mic_sample_fifo
  import mic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic              clk_sclk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              full,
  output logic              drop
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       rd_nx;
  logic              empty;
  logic              do_pop;
  logic              do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid   = !empty;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign rd_nx   = do_pop ? rd_ptr + (AW+1)'(1) : rd_ptr;

  always_ff @(posedge clk_sclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Head register: bypass the incoming word when it becomes the new head
  // (write into empty queue, or popping the last entry while writing).
  always_ff @(posedge clk_sclk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      rd_ptr <= rd_nx;
      if (do_push && (wr_ptr[AW-1:0] == rd_nx[AW-1:0]))
        dout <= din;
      else
        dout <= mem[rd_nx[AW-1:0]];
    end
  end

endmodule

// File: rtl/mic_sample_deser.sv
// PmodMIC frame deserializer: shifts sdata while ncs is low, validates length/header, queues samples.
// MIC_SIGNED_OUT_EN: when defined, samples are converted from offset binary to two's complement.
module mic_sample_deser
  import mic_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LEAD_ZEROS = LEAD_ZEROS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk_sclk,
  input  logic              rst,
  input  logic              ncs,
  input  logic              sdata,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic [7:0]        ovr_count
);

  localparam int FRM_LEN = DATA_W + LEAD_ZEROS;
  localparam int CNT_W   = cnt_width(FRM_LEN);

  logic [FRM_LEN-1:0] shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic               long_flag;
  frame_evt_e         evt;
  logic [DATA_W-1:0]  sample_conv;
  logic               push_vld;
  logic [DATA_W-1:0]  push_data;
  logic               fifo_full;
  logic               drop;

  // Frame checker: evaluated on the first edge that sees ncs high after bits arrived.
  always_comb begin
    evt = FR_NONE;
    if (ncs && (bit_cnt != '0)) begin
      if ((bit_cnt == CNT_W'(FRM_LEN)) && !long_flag &&
          (shreg[FRM_LEN-1 -: LEAD_ZEROS] == '0))
        evt = FR_GOOD;
      else
        evt = FR_BAD;
    end
  end

`ifdef MIC_SIGNED_OUT_EN
  assign sample_conv = {~shreg[DATA_W-1], shreg[DATA_W-2:0]};
`else
  assign sample_conv = shreg[DATA_W-1:0];
`endif

  always_ff @(posedge clk_sclk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      long_flag <= 1'b0;
    end else if (!ncs) begin
      if (bit_cnt < CNT_W'(FRM_LEN)) begin
        shreg   <= {shreg[FRM_LEN-2:0], sdata};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else begin
        long_flag <= 1'b1;
      end
    end else if (bit_cnt != '0) begin
      bit_cnt   <= '0;
      long_flag <= 1'b0;
    end
  end

  // One register stage between checker and queue: valid appears two edges after ncs rises.
  always_ff @(posedge clk_sclk or posedge rst) begin
    if (rst) begin
      push_vld  <= 1'b0;
      push_data <= '0;
      frame_err <= 1'b0;
    end else begin
      push_vld  <= (evt == FR_GOOD);
      frame_err <= (evt == FR_BAD);
      if (evt == FR_GOOD) push_data <= sample_conv;
    end
  end

  mic_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_sclk (clk_sclk),
    .rst      (rst),
    .push     (push_vld),
    .din      (push_data),
    .pop      (sample_ready),
    .dout     (sample_data),
    .valid    (sample_valid),
    .full     (fifo_full),
    .drop     (drop)
  );

  always_ff @(posedge clk_sclk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      ovr_count <= '0;
    end else begin
      overrun <= drop;
      if (drop && (ovr_count != 8'hFF)) ovr_count <= ovr_count + 8'd1;
    end
  end

endmodule
